ddr3_dfi_partial_wr: RTL and testbench
======================================

// Module: ddr3_dfi_partial_wr
// PURPOSE
//  Parametrised DFI-side partial-write injector between ddr3_core DFI outputs and the PHY.
//  Per write burst, forces byte masks so only the first N beats and/or selected byte lanes reach the DRAM.
//  Truncates writes, writes selected byte lanes, or writes nothing, with no change to core timing.
//  Adds one register stage to every DFI output (command and data) so their relative alignment is preserved.
// PARAMETERS
//  DFI_DATA_W   32  DFI write data width; MASK_W = DFI_DATA_W/8
//  BURST_BEATS  4   DFI beats per DDR write burst (1..255)
//  STAT_W       16  width of statistics counters
// PORTS
//  clk_i               in   1          clock
//  rst_i               in   1          synchronous active-high reset
//  cfg_valid_i         in   1          config write request
//  cfg_ready_o         out  1          config accepted when valid&ready
//  cfg_mode_i          in   2          0 BYPASS, 1 TRUNC, 2 BYTE, 3 TRUNC_BYTE
//  cfg_beats_i         in   8          beats kept per burst in TRUNC modes
//  cfg_byte_mask_i     in   MASK_W     lanes forced masked in BYTE modes (1 = masked)
//  stat_clr_i          in   1          clear statistics counters
//  stat_burst_o        out  STAT_W     write bursts seen
//  stat_partial_o      out  STAT_W     bursts modified
//  busy_o              out  1          burst in progress
//  dfi_*_i             in   as core    address[14:0], bank[2:0], ras_n, cas_n, we_n, cs_n, cke, odt, reset_n, rddata_en
//  dfi_wrdata_i        in   DFI_DATA_W write data from core
//  dfi_wrdata_en_i     in   1          write data enable from core
//  dfi_wrdata_mask_i   in   MASK_W     write mask from core
//  dfi_*_o             out  as inputs  registered copies of all above, to PHY
// BEHAVIOUR
//  - Latency: every dfi_*_o = dfi_*_i delayed exactly 1 clk; wrdata/mask values stay unchanged except as stated below.
//  - Reset values: cs_n/ras_n/cas_n/we_n = 1; cke, odt, reset_n, wrdata_en, rddata_en = 0; address, bank, wrdata = 0;
//    wrdata_mask = 0; cfg_ready_o = 1; busy_o = 0; stats = 0.
//    Config resets to mode 0, beats = BURST_BEATS, byte_mask = 0.
//  - Beat counter idx (8b): idx = 0 when wrdata_en_i = 0.
//    On an enabled beat, idx increments, wrapping BURST_BEATS-1 -> 0.
//    Back-to-back bursts with no gap are therefore split correctly.
//  - States: IDLE (idx = 0, en low) -> BURST on en_i = 1.
//    BURST -> IDLE when the last beat (idx = BURST_BEATS-1) has en_i = 0 next cycle, or when en_i drops early.
//    An early drop clears idx. BURST stays in BURST if en_i remains 1 (next burst).
//    busy_o = (state == BURST).
//  - Mask generation per enabled beat (out_mask = in_mask | force):
//    BYPASS: force = 0.
//    TRUNC: force = all-ones if idx >= cfg_beats, else 0.
//    BYTE: force = cfg_byte_mask.
//    TRUNC_BYTE: force = all-ones if idx >= cfg_beats, else cfg_byte_mask.
//    cfg_beats = 0 masks the whole burst. cfg_beats >= BURST_BEATS means no truncation.
//  - Active config is snapshotted at the first beat (idx = 0) and held for that burst.
//  - Config handshake: cfg_ready_o = 1 only in IDLE with en_i = 0.
//    An accepted config is visible from the next cycle. A cfg_valid_i arriving mid-burst waits; it is never dropped.
//  - Stats, updated on the first beat of each burst:
//    stat_burst_o += 1.
//    stat_partial_o += 1 if the snapshot forces any lane on any beat.
//    Both counters saturate at all-ones. stat_clr_i has priority over an increment in the same cycle.
//  - rst_i mid-burst: outputs return to reset values the next cycle and idx = 0; config and stats reset.
// CONFIGURATION
//  DDR3_PWR_WRDATA_ZERO_EN defined: beats fully forced to all-ones mask also drive dfi_wrdata_o = 0.
//    This cuts bus toggling and eases waveform debug.
//  Undefined: dfi_wrdata_o always equals the delayed dfi_wrdata_i.
// TESTING
//  1 Reset, mode 0, 4-beat burst with data A0..A3 and mask 0 -> identical data/mask/en 1 clk later;
//    stat_burst = 1, stat_partial = 0.
//  2 Mode 1, beats = 2, 4-beat burst -> out masks 0, 0, F, F; stat_partial = 1;
//    with beats = 0 -> F, F, F, F; with beats = 4 -> unmodified.
//  3 Mode 3, beats = 3, byte_mask = 4'b0011, two back-to-back bursts (8 en cycles)
//    -> masks 3, 3, 3, F, 3, 3, 3, F; stat_burst = 2.
//  4 cfg_valid_i raised at beat 1 of a burst -> cfg_ready_o stays 0 until IDLE;
//    current burst uses the old config, the next burst uses the new one.
//  5 Command alignment: WRITE cmd (cs_n = 0, ras_n = 1, cas_n = 0, we_n = 0) and wrdata_en separated by
//    WL cycles at the input -> same WL separation at the output.
//  6 rst_i asserted at beat 2 -> next cycle en_o = 0, mask = 0, cs_n = 1, stats = 0;
//    stat counter preset near max -> saturates at 16'hFFFF.
//    With DDR3_PWR_WRDATA_ZERO_EN: forced beats show wrdata_o = 0.

Source files
------------

// File: rtl/ddr3_dfi_partial_wr.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_dfi_partial_wr
// Description : DFI write-path partial-write injector. It registers every DFI
//               signal once and forces write byte masks per burst (truncate /
//               byte-lane / both). Option macro DDR3_PWR_WRDATA_ZERO_EN zeroes
//               the write data on fully masked beats.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_dfi_partial_wr #(
    parameter int  DFI_DATA_W  = 32,
    parameter int  BURST_BEATS = 4,
    parameter int  STAT_W      = 16,
    localparam int MASK_W      = DFI_DATA_W / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [1:0]            cfg_mode_i,
    input  logic [7:0]            cfg_beats_i,
    input  logic [MASK_W-1:0]     cfg_byte_mask_i,
    input  logic                  stat_clr_i,
    output logic [STAT_W-1:0]     stat_burst_o,
    output logic [STAT_W-1:0]     stat_partial_o,
    output logic                  busy_o,
    input  logic [14:0]           dfi_address_i,
    input  logic [2:0]            dfi_bank_i,
    input  logic                  dfi_ras_n_i,
    input  logic                  dfi_cas_n_i,
    input  logic                  dfi_we_n_i,
    input  logic                  dfi_cs_n_i,
    input  logic                  dfi_cke_i,
    input  logic                  dfi_odt_i,
    input  logic                  dfi_reset_n_i,
    input  logic                  dfi_rddata_en_i,
    input  logic [DFI_DATA_W-1:0] dfi_wrdata_i,
    input  logic                  dfi_wrdata_en_i,
    input  logic [MASK_W-1:0]     dfi_wrdata_mask_i,
    output logic [14:0]           dfi_address_o,
    output logic [2:0]            dfi_bank_o,
    output logic                  dfi_ras_n_o,
    output logic                  dfi_cas_n_o,
    output logic                  dfi_we_n_o,
    output logic                  dfi_cs_n_o,
    output logic                  dfi_cke_o,
    output logic                  dfi_odt_o,
    output logic                  dfi_reset_n_o,
    output logic                  dfi_rddata_en_o,
    output logic [DFI_DATA_W-1:0] dfi_wrdata_o,
    output logic                  dfi_wrdata_en_o,
    output logic [MASK_W-1:0]     dfi_wrdata_mask_o
);

    localparam logic [0:0] c_IDLE      = 1'b0;
    localparam logic [0:0] c_BURST     = 1'b1;
    localparam logic [7:0] c_LAST      = 8'(BURST_BEATS - 1);
    localparam logic [7:0] c_BEATS_RST = 8'(BURST_BEATS);

    logic [0:0]        r_state;
    logic [7:0]        r_idx;
    logic [1:0]        r_cfg_mode;
    logic [7:0]        r_cfg_beats;
    logic [MASK_W-1:0] r_cfg_byte_mask;
    logic [1:0]        r_snap_mode;
    logic [7:0]        r_snap_beats;
    logic [MASK_W-1:0] r_snap_byte_mask;
    logic [STAT_W-1:0] r_stat_burst;
    logic [STAT_W-1:0] r_stat_partial;

    logic                  w_first;
    logic [1:0]            w_mode;
    logic [7:0]            w_beats;
    logic [MASK_W-1:0]     w_byte_mask;
    logic [MASK_W-1:0]     w_force;
    logic                  w_cfg_ready;
    logic                  w_cfg_accept;
    logic                  w_cfg_forces;
    logic [DFI_DATA_W-1:0] w_wrdata;

    // The first beat of a burst uses the live config; later beats use the snapshot.
    assign w_first     = dfi_wrdata_en_i && (r_idx == 8'd0);
    assign w_mode      = w_first ? r_cfg_mode      : r_snap_mode;
    assign w_beats     = w_first ? r_cfg_beats     : r_snap_beats;
    assign w_byte_mask = w_first ? r_cfg_byte_mask : r_snap_byte_mask;

    // Mode bit 0 enables truncation, bit 1 enables byte-lane masking.
    always_comb begin
        w_force = '0;
        if (dfi_wrdata_en_i) begin
            if (w_mode[0] && (r_idx >= w_beats)) begin
                w_force = '1;
            end else if (w_mode[1]) begin
                w_force = w_byte_mask;
            end
        end
    end

    assign w_cfg_forces = (r_cfg_mode[0] && (r_cfg_beats < c_BEATS_RST)) ||
                          (r_cfg_mode[1] && (r_cfg_byte_mask != '0));

`ifdef DDR3_PWR_WRDATA_ZERO_EN
    assign w_wrdata = (&w_force) ? '0 : dfi_wrdata_i;
`else
    assign w_wrdata = dfi_wrdata_i;
`endif

    assign w_cfg_ready    = (r_state == c_IDLE) && !dfi_wrdata_en_i;
    assign w_cfg_accept   = cfg_valid_i && w_cfg_ready;
    assign cfg_ready_o    = w_cfg_ready;
    assign busy_o         = (r_state == c_BURST);
    assign stat_burst_o   = r_stat_burst;
    assign stat_partial_o = r_stat_partial;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dfi_address_o     <= '0;
            dfi_bank_o        <= '0;
            dfi_ras_n_o       <= 1'b1;
            dfi_cas_n_o       <= 1'b1;
            dfi_we_n_o        <= 1'b1;
            dfi_cs_n_o        <= 1'b1;
            dfi_cke_o         <= 1'b0;
            dfi_odt_o         <= 1'b0;
            dfi_reset_n_o     <= 1'b0;
            dfi_rddata_en_o   <= 1'b0;
            dfi_wrdata_o      <= '0;
            dfi_wrdata_en_o   <= 1'b0;
            dfi_wrdata_mask_o <= '0;
            r_state           <= c_IDLE;
            r_idx             <= '0;
            r_cfg_mode        <= 2'd0;
            r_cfg_beats       <= c_BEATS_RST;
            r_cfg_byte_mask   <= '0;
            r_snap_mode       <= 2'd0;
            r_snap_beats      <= c_BEATS_RST;
            r_snap_byte_mask  <= '0;
            r_stat_burst      <= '0;
            r_stat_partial    <= '0;
        end else begin
            dfi_address_o     <= dfi_address_i;
            dfi_bank_o        <= dfi_bank_i;
            dfi_ras_n_o       <= dfi_ras_n_i;
            dfi_cas_n_o       <= dfi_cas_n_i;
            dfi_we_n_o        <= dfi_we_n_i;
            dfi_cs_n_o        <= dfi_cs_n_i;
            dfi_cke_o         <= dfi_cke_i;
            dfi_odt_o         <= dfi_odt_i;
            dfi_reset_n_o     <= dfi_reset_n_i;
            dfi_rddata_en_o   <= dfi_rddata_en_i;
            dfi_wrdata_o      <= w_wrdata;
            dfi_wrdata_en_o   <= dfi_wrdata_en_i;
            dfi_wrdata_mask_o <= dfi_wrdata_mask_i | w_force;

            r_state <= dfi_wrdata_en_i ? c_BURST : c_IDLE;

            // Wrapping index splits gapless back-to-back bursts.
            if (dfi_wrdata_en_i) begin
                r_idx <= (r_idx == c_LAST) ? 8'd0 : r_idx + 8'd1;
            end else begin
                r_idx <= 8'd0;
            end

            if (w_first) begin
                r_snap_mode      <= r_cfg_mode;
                r_snap_beats     <= r_cfg_beats;
                r_snap_byte_mask <= r_cfg_byte_mask;
            end

            if (w_cfg_accept) begin
                r_cfg_mode      <= cfg_mode_i;
                r_cfg_beats     <= cfg_beats_i;
                r_cfg_byte_mask <= cfg_byte_mask_i;
            end

            if (stat_clr_i) begin
                r_stat_burst   <= '0;
                r_stat_partial <= '0;
            end else if (w_first) begin
                if (r_stat_burst != '1) begin
                    r_stat_burst <= r_stat_burst + 1'b1;
                end
                if (w_cfg_forces && (r_stat_partial != '1)) begin
                    r_stat_partial <= r_stat_partial + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_dfi_partial_wr.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_dfi_partial_wr
// Description : Self-checking bench for ddr3_dfi_partial_wr with a burst-level
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_dfi_partial_wr;

    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int BB = 4;
    localparam int SW = 16;
    localparam int WL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_mode = '0;
    logic [7:0]    cfg_beats = '0;
    logic [MW-1:0] cfg_byte_mask = '0;
    logic          stat_clr = 1'b0;
    logic [SW-1:0] stat_burst, stat_partial;
    logic          busy;
    logic [14:0]   address_i = '0;
    logic [2:0]    bank_i = '0;
    logic          ras_n_i = 1'b1, cas_n_i = 1'b1, we_n_i = 1'b1, cs_n_i = 1'b1;
    logic          cke_i = 1'b0, odt_i = 1'b0, reset_n_i = 1'b0, rddata_en_i = 1'b0;
    logic [DW-1:0] wrdata_i = '0;
    logic          wrdata_en_i = 1'b0;
    logic [MW-1:0] wrdata_mask_i = '0;
    logic [14:0]   address_o;
    logic [2:0]    bank_o;
    logic          ras_n_o, cas_n_o, we_n_o, cs_n_o, cke_o, odt_o, reset_n_o, rddata_en_o;
    logic [DW-1:0] wrdata_o;
    logic          wrdata_en_o;
    logic [MW-1:0] wrdata_mask_o;

    ddr3_dfi_partial_wr #(.DFI_DATA_W(DW), .BURST_BEATS(BB), .STAT_W(SW)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_mode_i(cfg_mode),
        .cfg_beats_i(cfg_beats), .cfg_byte_mask_i(cfg_byte_mask),
        .stat_clr_i(stat_clr), .stat_burst_o(stat_burst), .stat_partial_o(stat_partial),
        .busy_o(busy),
        .dfi_address_i(address_i), .dfi_bank_i(bank_i), .dfi_ras_n_i(ras_n_i),
        .dfi_cas_n_i(cas_n_i), .dfi_we_n_i(we_n_i), .dfi_cs_n_i(cs_n_i),
        .dfi_cke_i(cke_i), .dfi_odt_i(odt_i), .dfi_reset_n_i(reset_n_i),
        .dfi_rddata_en_i(rddata_en_i), .dfi_wrdata_i(wrdata_i),
        .dfi_wrdata_en_i(wrdata_en_i), .dfi_wrdata_mask_i(wrdata_mask_i),
        .dfi_address_o(address_o), .dfi_bank_o(bank_o), .dfi_ras_n_o(ras_n_o),
        .dfi_cas_n_o(cas_n_o), .dfi_we_n_o(we_n_o), .dfi_cs_n_o(cs_n_o),
        .dfi_cke_o(cke_o), .dfi_odt_o(odt_o), .dfi_reset_n_o(reset_n_o),
        .dfi_rddata_en_o(rddata_en_o), .dfi_wrdata_o(wrdata_o),
        .dfi_wrdata_en_o(wrdata_en_o), .dfi_wrdata_mask_o(wrdata_mask_o)
    );

    // Small instance used to reach counter saturation quickly.
    logic       sat_cfg_valid = 1'b0, sat_cfg_ready, sat_clr = 1'b0, sat_busy, sat_en = 1'b0;
    logic [3:0] sat_burst, sat_partial;
    logic [14:0] sat_address_o;
    logic [2:0]  sat_bank_o;
    logic        sat_ras_n_o, sat_cas_n_o, sat_we_n_o, sat_cs_n_o, sat_cke_o, sat_odt_o;
    logic        sat_reset_n_o, sat_rddata_en_o, sat_en_o;
    logic [15:0] sat_wrdata_o;
    logic [1:0]  sat_mask_o;

    ddr3_dfi_partial_wr #(.DFI_DATA_W(16), .BURST_BEATS(2), .STAT_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst),
        .cfg_valid_i(sat_cfg_valid), .cfg_ready_o(sat_cfg_ready), .cfg_mode_i(2'd1),
        .cfg_beats_i(8'd1), .cfg_byte_mask_i(2'b00),
        .stat_clr_i(sat_clr), .stat_burst_o(sat_burst), .stat_partial_o(sat_partial),
        .busy_o(sat_busy),
        .dfi_address_i(address_i), .dfi_bank_i(bank_i), .dfi_ras_n_i(ras_n_i),
        .dfi_cas_n_i(cas_n_i), .dfi_we_n_i(we_n_i), .dfi_cs_n_i(cs_n_i),
        .dfi_cke_i(cke_i), .dfi_odt_i(odt_i), .dfi_reset_n_i(reset_n_i),
        .dfi_rddata_en_i(rddata_en_i), .dfi_wrdata_i(wrdata_i[15:0]),
        .dfi_wrdata_en_i(sat_en), .dfi_wrdata_mask_i(2'b00),
        .dfi_address_o(sat_address_o), .dfi_bank_o(sat_bank_o), .dfi_ras_n_o(sat_ras_n_o),
        .dfi_cas_n_o(sat_cas_n_o), .dfi_we_n_o(sat_we_n_o), .dfi_cs_n_o(sat_cs_n_o),
        .dfi_cke_o(sat_cke_o), .dfi_odt_o(sat_odt_o), .dfi_reset_n_o(sat_reset_n_o),
        .dfi_rddata_en_o(sat_rddata_en_o), .dfi_wrdata_o(sat_wrdata_o),
        .dfi_wrdata_en_o(sat_en_o), .dfi_wrdata_mask_o(sat_mask_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (burst-level view) ----------------
    localparam logic [25:0] CMD_RST = {15'd0, 3'd0, 4'b1111, 4'b0000};

    function automatic logic [MW-1:0] force_at(input int pos, input logic [1:0] mode,
                                               input logic [7:0] beats, input logic [MW-1:0] bm);
        if ((mode == 2'd1 || mode == 2'd3) && pos >= int'(beats)) return '1;
        if (mode == 2'd2 || mode == 2'd3) return bm;
        return '0;
    endfunction

    function automatic bit burst_modified(input logic [1:0] mode, input logic [7:0] beats,
                                          input logic [MW-1:0] bm);
        for (int p = 0; p < BB; p++) if (force_at(p, mode, beats, bm) != '0) return 1'b1;
        return 1'b0;
    endfunction

    logic [25:0]   exp_cmd;
    logic [DW-1:0] exp_data;
    logic [MW-1:0] exp_mask;
    logic          exp_en;
    logic [SW-1:0] m_burst, m_partial;
    logic [1:0]    m_mode, s_mode;
    logic [7:0]    m_beats, s_beats;
    logic [MW-1:0] m_bm, s_bm;
    int            m_run;
    bit            m_prev_en, model_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_cmd = CMD_RST; exp_data = '0; exp_mask = '0; exp_en = 1'b0;
            m_mode = 2'd0; m_beats = 8'(BB); m_bm = '0;
            s_mode = 2'd0; s_beats = 8'(BB); s_bm = '0;
            m_burst = '0; m_partial = '0; m_run = 0; m_prev_en = 1'b0;
        end else begin
            exp_cmd  = {address_i, bank_i, ras_n_i, cas_n_i, we_n_i, cs_n_i,
                        cke_i, odt_i, reset_n_i, rddata_en_i};
            exp_data = wrdata_i;
            exp_mask = wrdata_mask_i;
            exp_en   = wrdata_en_i;
            if (wrdata_en_i) begin
                if (m_run % BB == 0) begin
                    s_mode = m_mode; s_beats = m_beats; s_bm = m_bm;
                    if (m_burst != '1) m_burst = m_burst + 1'b1;
                    if (burst_modified(s_mode, s_beats, s_bm) && m_partial != '1)
                        m_partial = m_partial + 1'b1;
                end
                exp_mask = wrdata_mask_i | force_at(m_run % BB, s_mode, s_beats, s_bm);
`ifdef DDR3_PWR_WRDATA_ZERO_EN
                if (force_at(m_run % BB, s_mode, s_beats, s_bm) == '1) exp_data = '0;
`endif
                m_run++;
            end else begin
                m_run = 0;
            end
            if (stat_clr) begin
                m_burst = '0; m_partial = '0;
            end
            if (cfg_valid && !m_prev_en && !wrdata_en_i) begin
                m_mode = cfg_mode; m_beats = cfg_beats; m_bm = cfg_byte_mask;
            end
            m_prev_en = wrdata_en_i;
        end
        model_live = 1'b1;
    end

    // ---------------- compare / capture / timing monitor ----------------
    logic [MW-1:0] cap_mask[$];
    logic [DW-1:0] cap_data[$];
    int cyc = 0, t_cmd_i = -1, t_cmd_o = -1, t_en_i = -1, t_en_o = -1;
    bit pen_i = 1'b0, pen_o = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (model_live) begin
            check("cmd", {address_o, bank_o, ras_n_o, cas_n_o, we_n_o, cs_n_o,
                          cke_o, odt_o, reset_n_o, rddata_en_o}, exp_cmd);
            check("wrdata", wrdata_o, exp_data);
            check("mask", wrdata_mask_o, exp_mask);
            check("wrdata_en", wrdata_en_o, exp_en);
            check("stat_burst", stat_burst, m_burst);
            check("stat_partial", stat_partial, m_partial);
            check("busy", busy, m_prev_en);
            check("cfg_ready", cfg_ready, !m_prev_en && !wrdata_en_i);
            if (wrdata_en_o) begin
                cap_mask.push_back(wrdata_mask_o);
                cap_data.push_back(wrdata_o);
            end
        end
        if (!cs_n_i && ras_n_i && !cas_n_i && !we_n_i) t_cmd_i = cyc;
        if (!cs_n_o && ras_n_o && !cas_n_o && !we_n_o) t_cmd_o = cyc;
        if (wrdata_en_i && !pen_i) t_en_i = cyc;
        if (wrdata_en_o && !pen_o) t_en_o = cyc;
        pen_i = wrdata_en_i;
        pen_o = wrdata_en_o;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int n, input logic [DW-1:0] base, input logic [MW-1:0] inmask);
        for (int i = 0; i < n; i++) begin
            wrdata_en_i = 1'b1; wrdata_i = base + DW'(i); wrdata_mask_i = inmask;
            odt_i = 1'b1;
            tick();
        end
        wrdata_en_i = 1'b0; wrdata_i = '0; wrdata_mask_i = '0; odt_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic cfg_write(input logic [1:0] mode, input logic [7:0] beats,
                             input logic [MW-1:0] bm, output int waited);
        bit got = 1'b0;
        cfg_mode = mode; cfg_beats = beats; cfg_byte_mask = bm; cfg_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cfg_ready) got = 1'b1;
            else waited++;
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        if (!got) check("cfg_timeout", 64'd0, 64'd1);
    endtask

    // Expected masks packed one nibble per beat, first beat in the top nibble.
    task automatic check_masks(input string name, input int n, input logic [31:0] exp);
        check({name, "_count"}, 64'(cap_mask.size()), 64'(n));
        for (int i = 0; i < n && i < cap_mask.size(); i++)
            check(name, 64'(cap_mask[i]), 64'(exp[4*(n-1-i) +: 4]));
        cap_mask.delete();
        cap_data.delete();
    endtask

    int w;

    initial begin
        // 1: reset values, bypass passthrough
        tick(); tick();
        @(negedge clk);
        check("rst_cs_n", cs_n_o, 1'b1);
        check("rst_en", wrdata_en_o, 1'b0);
        check("rst_ready", cfg_ready, 1'b1);
        check("rst_stat", {stat_burst, stat_partial}, 32'd0);
        tick();
        rst = 1'b0; cke_i = 1'b1; reset_n_i = 1'b1;
        tick();
        cap_mask.delete(); cap_data.delete();
        burst(4, 32'hA0, '0);
        check("t1_data0", cap_data[0], 32'hA0);
        check("t1_data3", cap_data[3], 32'hA3);
        check_masks("t1_mask", 4, 32'h0000);
        check("t1_stats", {stat_burst, stat_partial}, {16'd1, 16'd0});

        // 2: truncation
        cfg_write(2'd1, 8'd2, 4'h0, w);
        burst(4, 32'hB0, '0);
        check_masks("t2_trunc2", 4, 32'h00FF);
        check("t2_partial", stat_partial, 16'd1);
        cfg_write(2'd1, 8'd0, 4'h0, w);
        burst(4, 32'hB4, '0);
        check_masks("t2_trunc0", 4, 32'hFFFF);
        cfg_write(2'd1, 8'd4, 4'h0, w);
        burst(4, 32'hB8, 4'b0100);
        check_masks("t2_trunc4", 4, 32'h4444);

        // 3: truncate + byte lanes, gapless back-to-back bursts
        cfg_write(2'd3, 8'd3, 4'b0011, w);
        burst(8, 32'hC0, '0);
        check_masks("t3_mask", 8, 32'h333F333F);
        check("t3_stats", {stat_burst, stat_partial}, {16'd6, 16'd4});

        // 4: config request during a burst waits for idle
        cfg_write(2'd0, 8'd4, 4'h0, w);
        fork
            burst(4, 32'hD0, '0);
            begin tick(); cfg_write(2'd2, 8'd4, 4'b1000, w); end
        join
        check("t4_wait", 64'(w), 64'd4);
        check_masks("t4_old_cfg", 4, 32'h0000);
        burst(4, 32'hD4, '0);
        check_masks("t4_new_cfg", 4, 32'h8888);

        // 5: command to write-data spacing preserved
        address_i = 15'h123; bank_i = 3'd5;
        cs_n_i = 1'b0; ras_n_i = 1'b1; cas_n_i = 1'b0; we_n_i = 1'b0;
        tick();
        cs_n_i = 1'b1; cas_n_i = 1'b1; we_n_i = 1'b1; address_i = '0; bank_i = '0;
        rddata_en_i = 1'b1;
        tick();
        rddata_en_i = 1'b0;
        for (int i = 0; i < WL - 2; i++) tick();
        burst(4, 32'hE0, '0);
        check("t5_in_sep", 64'(t_en_i - t_cmd_i), 64'(WL));
        check("t5_out_sep", 64'(t_en_o - t_cmd_o), 64'(WL));
        check("t5_cmd_lat", 64'(t_cmd_o - t_cmd_i), 64'd1);
        cap_mask.delete(); cap_data.delete();

        // 6: reset mid-burst
        cfg_write(2'd1, 8'd2, 4'h0, w);
        wrdata_en_i = 1'b1; wrdata_i = 32'hF0; tick();
        wrdata_i = 32'hF1; tick();
        wrdata_i = 32'hF2; rst = 1'b1; cs_n_i = 1'b0; tick();
        rst = 1'b0; wrdata_en_i = 1'b0; wrdata_i = '0; cs_n_i = 1'b1;
        @(negedge clk);
        check("t6_en", wrdata_en_o, 1'b0);
        check("t6_mask", wrdata_mask_o, 4'h0);
        check("t6_cs_n", cs_n_o, 1'b1);
        check("t6_stats", {stat_burst, stat_partial}, 32'd0);
        tick();
        cap_mask.delete(); cap_data.delete();
        burst(4, 32'h60, '0);
        check_masks("t6_cfg_rst", 4, 32'h0000);
        check("t6_burst", stat_burst, 16'd1);

        // saturation and clear priority on the small instance
        sat_cfg_valid = 1'b1; tick(); sat_cfg_valid = 1'b0;
        sat_en = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        sat_en = 1'b0; tick();
        @(negedge clk);
        check("sat_burst", sat_burst, 4'hF);
        check("sat_partial", sat_partial, 4'hF);
        tick();
        sat_en = 1'b1; sat_clr = 1'b1; tick();
        sat_clr = 1'b0; tick();
        sat_en = 1'b0; tick();
        @(negedge clk);
        check("sat_clr_prio", {sat_burst, sat_partial}, 8'h00);
        tick();
        sat_en = 1'b1; tick(); tick();
        sat_en = 1'b0; tick();
        @(negedge clk);
        check("sat_after_clr", {sat_burst, sat_partial}, 8'h11);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
